// File: rtl/can_regbus_pkg.sv
// Shared types and constants for the CAN register-bus sequencer.
// Holds the FSM state encoding and the requester port encoding.
package can_regbus_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

endpackage

// File: rtl/can_rr_arbiter2.sv
// Two-way round-robin arbiter with a last-grant register.
// The grant index is combinational; last-grant updates only on load.
module can_rr_arbiter2 (
    input  logic clock,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic load,
    output logic grant
);
    import can_regbus_pkg::*;

    logic last;

    // On a tie the port not granted last wins.
    always_comb begin
        grant = PORT_A;
        if (req_a && req_b) begin
            grant = ~last;
        end else if (req_b) begin
            grant = PORT_B;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last <= PORT_B;
        end else if (load) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/can_regbus_sequencer.sv
// Shares the CAN register-file bus between two Avalon-MM requesters,
// sequencing cs/strobe phases and completing with waitrequest.
module can_regbus_sequencer #(
    parameter int STROBE_CYCLES = 1,
    parameter int ADDR_W        = can_regbus_pkg::ADDR_W,
    parameter int DATA_W        = can_regbus_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_waitrequest,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_waitrequest,
    output logic [ADDR_W-1:0] reg_address,
    output logic [DATA_W-1:0] reg_writedata,
    output logic              reg_cs,
    output logic              reg_read_n,
    output logic              reg_write_n,
    input  logic [DATA_W-1:0] reg_readdata,
    output logic              proto_err
);
    import can_regbus_pkg::*;

    localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       dir;
    logic       sel;
    logic       req_a;
    logic       req_b;
    logic       grant;
    logic       load;
    logic       last_strobe;

    assign req_a       = a_read | a_write;
    assign req_b       = b_read | b_write;
    assign last_strobe = (state == STROBE) && (cnt == '0);

    can_rr_arbiter2 u_arb (
        .clock (clock),
        .reset (reset),
        .req_a (req_a),
        .req_b (req_b),
        .load  (load),
        .grant (grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        load          = 1'b0;
        reg_cs        = 1'b0;
        reg_read_n    = 1'b1;
        reg_write_n   = 1'b1;
        a_waitrequest = 1'b1;
        b_waitrequest = 1'b1;
        unique case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    load       = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                reg_cs     = 1'b1;
                state_next = STROBE;
            end
            STROBE: begin
                reg_cs      = 1'b1;
                reg_write_n = ~dir;
                reg_read_n  = dir;
                if (cnt == '0) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                reg_cs        = 1'b1;
                a_waitrequest = (sel != PORT_A);
                b_waitrequest = (sel != PORT_B);
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt           <= '0;
            dir           <= 1'b0;
            sel           <= PORT_A;
            reg_address   <= '0;
            reg_writedata <= '0;
            a_readdata    <= '0;
            b_readdata    <= '0;
            proto_err     <= 1'b0;
        end else begin
            if (load) begin
                sel <= grant;
                // Read+write together is resolved as a write.
                if (grant == PORT_A) begin
                    reg_address   <= a_address;
                    reg_writedata <= a_writedata;
                    dir           <= a_write;
                    if (a_read && a_write) begin
                        proto_err <= 1'b1;
                    end
                end else begin
                    reg_address   <= b_address;
                    reg_writedata <= b_writedata;
                    dir           <= b_write;
                    if (b_read && b_write) begin
                        proto_err <= 1'b1;
                    end
                end
            end
            if (state == SETUP) begin
                cnt <= CNT_INIT;
            end else if (state == STROBE && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (last_strobe && !dir) begin
                if (sel == PORT_A) begin
                    a_readdata <= reg_readdata;
                end else begin
                    b_readdata <= reg_readdata;
                end
            end
        end
    end

endmodule
